aha_sram_arbiter: RTL and testbench

- Shares one single-port 32K x 32 SRAM (CEn/WEn/A/D/Q macro interface, 1-cycle read latency) between two requesters, e.g. CPU data port (R0) and DMA (R1).
- Round-robin arbitration with valid/grant handshake; returns read data tagged to the winning requester.
- After reset, optionally zero-fills the whole array so no SRAM word is read uninitialised.
- Sits between the SoC bus adapters and the SRAM wrapper.

---
 rtl/aha_sram_arb_pkg.sv | 20 ++
 rtl/aha_sram_arbiter_if.sv | 28 ++
 rtl/aha_rr_arb2.sv | 38 +++
 rtl/aha_sram_arbiter.sv | 135 +++++++++++++
 tb/tb_aha_sram_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/aha_sram_arb_pkg.sv
// aha_sram_arb_pkg
//   Shared types and helpers for the two-requester SRAM arbiter.
//   - state_t     : arbiter FSM states (INIT zero-fill, RUN normal service)
//   - NUM_REQ     : number of requesters sharing the SRAM
//   - be_to_wen() : one byte lane of active-high byte enable -> active-low SRAM WEn
package aha_sram_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int NUM_REQ = 2;

    // Applied per lane so the same helper serves any DATA_W.
    function automatic logic be_to_wen(input logic be);
        return ~be;
    endfunction

endpackage

// File: rtl/aha_sram_arbiter_if.sv
// aha_sram_arbiter_if
//   One requester's port into the SRAM arbiter.
//   master : requester side (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave  : arbiter side
//
//   Handshake: a requester raises req with we/addr/wdata and holds all four
//   stable until it sees gnt high in the same cycle; the access is taken on
//   the clock edge that ends that cycle. Dropping req before gnt withdraws the
//   request. we all-zero means read; a granted read returns rvalid high for
//   exactly one cycle, the cycle after the grant edge, with rdata valid then.
//   Writes never produce rvalid.
interface aha_sram_arbiter_if
    import aha_sram_arb_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic                  req;
    logic [DATA_W/8-1:0]   we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/aha_rr_arb2.sv
// aha_rr_arb2
//   Two-way round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset
//   advance  : allow rr_last to move on this cycle's grant
//   req[1:0] : requests
//   gnt[1:0] : one-hot grant, combinational from req and rr_last
//   A lone request always wins; on contention the requester that did not win
//   last time gets the slot.
module aha_rr_arb2
    import aha_sram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);
    // Index of the last winner; reset to 1 so R0 wins the first contention.
    logic rr_last;

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (advance && (|gnt)) begin
            rr_last <= gnt[1];
        end
    end
endmodule

// File: rtl/aha_sram_arbiter.sv
// aha_sram_arbiter
//   Shares one single-port SRAM (CEn/WEn/A/D/Q, 1-cycle read latency)
//   between two requesters with round-robin arbitration, optionally zero-
//   filling the array after reset.
//   clk, rst   : clock, synchronous active-high reset
//   r0, r1     : requester ports (see aha_sram_arbiter_if)
//   sram_cen   : chip enable, active-low
//   sram_wen   : byte write enables, active-low (all-ones = read)
//   sram_a/d   : address / write data
//   sram_q     : read data, valid the cycle after the access edge
//   init_done  : high while in RUN
//   dbg_state  : current FSM state
module aha_sram_arbiter
    import aha_sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 32,
    parameter bit INIT_ZERO = 1'b1
)(
    input  logic                clk,
    input  logic                rst,
    aha_sram_arbiter_if.slave   r0,
    aha_sram_arbiter_if.slave   r1,
    output logic                sram_cen,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_d,
    input  logic [DATA_W-1:0]   sram_q,
    output logic                init_done,
    output state_t              dbg_state
);
    localparam int BE_W = DATA_W / 8;

    state_t               state;
    logic [ADDR_W-1:0]    init_ctr;
    // Last address/data driven to the SRAM, held while the bus is idle.
    logic [ADDR_W-1:0]    a_hold;
    logic [DATA_W-1:0]    d_hold;
    logic                 r0_rvalid_q;
    logic                 r1_rvalid_q;

    logic                 run_ok;
    logic [NUM_REQ-1:0]   req_vec;
    logic [NUM_REQ-1:0]   gnt_vec;
    logic [BE_W-1:0]      win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_wdata;

    // Requests are invisible to the arbiter outside RUN and during reset.
    assign run_ok  = (state == ST_RUN) && !rst;
    assign req_vec = {r1.req, r0.req} & {NUM_REQ{run_ok}};

    aha_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .advance (run_ok),
        .req     (req_vec),
        .gnt     (gnt_vec)
    );

    always_comb begin
        win_we    = r0.we;
        win_addr  = r0.addr;
        win_wdata = r0.wdata;
        if (gnt_vec[1]) begin
            win_we    = r1.we;
            win_addr  = r1.addr;
            win_wdata = r1.wdata;
        end
    end

    always_comb begin
        sram_cen = 1'b1;
        sram_wen = '1;
        sram_a   = a_hold;
        sram_d   = d_hold;
        if (rst) begin
            sram_a = '0;
            sram_d = '0;
        end else if (state == ST_INIT) begin
            sram_cen = 1'b0;
            sram_wen = '0;
            sram_a   = init_ctr;
            sram_d   = '0;
        end else if (|gnt_vec) begin
            sram_cen = 1'b0;
            for (int i = 0; i < BE_W; i++) begin
                sram_wen[i] = be_to_wen(win_we[i]);
            end
            sram_a = win_addr;
            sram_d = win_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT_ZERO ? ST_INIT : ST_RUN;
            init_ctr    <= '0;
            a_hold      <= '0;
            d_hold      <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
        end else begin
            r0_rvalid_q <= gnt_vec[0] && (r0.we == '0);
            r1_rvalid_q <= gnt_vec[1] && (r1.we == '0);
            case (state)
                ST_INIT: begin
                    init_ctr <= init_ctr + ADDR_W'(1);
                    a_hold   <= init_ctr;
                    d_hold   <= '0;
                    if (init_ctr == '1) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (|gnt_vec) begin
                        a_hold <= win_addr;
                        d_hold <= win_wdata;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign r0.gnt    = gnt_vec[0];
    assign r1.gnt    = gnt_vec[1];
    // Gated by rst so a read in flight when reset lands never reports.
    assign r0.rvalid = r0_rvalid_q && !rst;
    assign r1.rvalid = r1_rvalid_q && !rst;
    assign r0.rdata  = sram_q;
    assign r1.rdata  = sram_q;
    assign init_done = (state == ST_RUN) && !rst;
    assign dbg_state = state;
endmodule

// File: tb/tb_aha_sram_arbiter.sv
module tb_aha_sram_arbiter;
    import aha_sram_arb_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NVEC   = 30;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    aha_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
    aha_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();

    logic              sram_cen;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;
    logic              init_done;
    state_t            dbg_state;

    aha_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0        (r0_if),
        .r1        (r1_if),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q),
        .init_done (init_done),
        .dbg_state (dbg_state)
    );

    // ---------------- SRAM macro model ----------------
    logic [DATA_W-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (!sram_cen) begin
            for (int i = 0; i < BE_W; i++) begin
                if (!sram_wen[i]) mem[sram_a][8*i +: 8] = sram_d[8*i +: 8];
            end
            if (sram_wen == '1) sram_q <= mem[sram_a];
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec;
    int n_bad;
    logic [ADDR_W-1:0] exp_q[$];

    typedef struct {
        logic              r0_req;
        logic [BE_W-1:0]   r0_we;
        logic [ADDR_W-1:0] r0_addr;
        logic [DATA_W-1:0] r0_wdata;
        logic              r1_req;
        logic [BE_W-1:0]   r1_we;
        logic [ADDR_W-1:0] r1_addr;
        logic [DATA_W-1:0] r1_wdata;
        logic              e_g0;
        logic              e_g1;
        logic              e_cen;
        logic [BE_W-1:0]   e_wen;
        logic [ADDR_W-1:0] e_a;
        logic [DATA_W-1:0] e_d;
        logic              e_rv0;
        logic              e_rv1;
        logic [DATA_W-1:0] e_rdata;
    } vec_t;

    vec_t vt [NVEC];

    function automatic vec_t mk(
        input logic q0, input logic [BE_W-1:0] w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
        input logic q1, input logic [BE_W-1:0] w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
        input logic g0, input logic g1, input logic cen, input logic [BE_W-1:0] wen,
        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
        input logic rv0, input logic rv1, input logic [DATA_W-1:0] rd);
        vec_t v;
        v.r0_req = q0; v.r0_we = w0; v.r0_addr = a0; v.r0_wdata = d0;
        v.r1_req = q1; v.r1_we = w1; v.r1_addr = a1; v.r1_wdata = d1;
        v.e_g0 = g0; v.e_g1 = g1; v.e_cen = cen; v.e_wen = wen; v.e_a = a; v.e_d = d;
        v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_all();
        r0_if.req = 1'b0; r0_if.we = '0; r0_if.addr = '0; r0_if.wdata = '0;
        r1_if.req = 1'b0; r1_if.we = '0; r1_if.addr = '0; r1_if.wdata = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".gnt"},   {r1_if.gnt, r0_if.gnt}, 0);
        chk({tag, ".rv"},    {r1_if.rvalid, r0_if.rvalid}, 0);
        chk({tag, ".cen"},   sram_cen, 1);
        chk({tag, ".wen"},   sram_wen, 4'hF);
        chk({tag, ".a"},     sram_a, 0);
        chk({tag, ".d"},     sram_d, 0);
        chk({tag, ".done"},  init_done, 0);
        chk({tag, ".state"}, dbg_state, ST_INIT);
    endtask

    // Caller has already released reset just after a rising edge.
    task automatic ramp(input int n, input string tag);
        for (int i = 0; i < n; i++) exp_q.push_back(ADDR_W'(i));
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] ea;
            if (i != 0) begin @(posedge clk); #1; end
            @(negedge clk);
            ea = exp_q.pop_front();
            chk({tag, ".a"},    sram_a, ea);
            chk({tag, ".cen"},  sram_cen, 0);
            chk({tag, ".wen"},  sram_wen, 0);
            chk({tag, ".d"},    sram_d, 0);
            chk({tag, ".done"}, init_done, 0);
            chk({tag, ".gnt"},  {r1_if.gnt, r0_if.gnt}, 0);
            chk({tag, ".rv"},   {r1_if.rvalid, r0_if.rvalid}, 0);
        end
    endtask

    task automatic apply(input int i);
        logic bad;
        @(posedge clk); #1;
        r0_if.req = vt[i].r0_req; r0_if.we = vt[i].r0_we; r0_if.addr = vt[i].r0_addr; r0_if.wdata = vt[i].r0_wdata;
        r1_if.req = vt[i].r1_req; r1_if.we = vt[i].r1_we; r1_if.addr = vt[i].r1_addr; r1_if.wdata = vt[i].r1_wdata;
        @(negedge clk);
        bad = (r0_if.gnt !== vt[i].e_g0) || (r1_if.gnt !== vt[i].e_g1) ||
              (sram_cen !== vt[i].e_cen) || (sram_wen !== vt[i].e_wen) ||
              (sram_a !== vt[i].e_a) || (sram_d !== vt[i].e_d) ||
              (r0_if.rvalid !== vt[i].e_rv0) || (r1_if.rvalid !== vt[i].e_rv1) ||
              (init_done !== 1'b1) ||
              (vt[i].e_rv0 && (r0_if.rdata !== vt[i].e_rdata)) ||
              (vt[i].e_rv1 && (r1_if.rdata !== vt[i].e_rdata));
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL row%0d: got g=%b%b cen=%b wen=%h a=%h d=%h rv=%b%b rdata=%h/%h done=%b want g=%b%b cen=%b wen=%h a=%h d=%h rv=%b%b rdata=%h done=1",
                     i, r0_if.gnt, r1_if.gnt, sram_cen, sram_wen, sram_a, sram_d, r0_if.rvalid, r1_if.rvalid,
                     r0_if.rdata, r1_if.rdata, init_done,
                     vt[i].e_g0, vt[i].e_g1, vt[i].e_cen, vt[i].e_wen, vt[i].e_a, vt[i].e_d,
                     vt[i].e_rv0, vt[i].e_rv1, vt[i].e_rdata);
        end
    endtask

    // ---------------- vector table ----------------
    task automatic fill_table();
        //            r0: req we    addr  wdata          r1: req we    addr  wdata          g0 g1 cen wen   a     d              rv0 rv1 rdata
        // first RUN segment: idle, zero-filled read, single requester, byte lanes
        vt[0]  = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'hF, 32'h0,          N, N, 32'h0);
        vt[1]  = mk(Y, 4'h0, 4'h9, 32'h0,          N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'hF, 4'h9, 32'h0,          N, N, 32'h0);
        vt[2]  = mk(Y, 4'hF, 4'h5, 32'hDEADBEEF,   N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'h0, 4'h5, 32'hDEADBEEF,   Y, N, 32'h0);
        vt[3]  = mk(Y, 4'h0, 4'h5, 32'h0,          N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'hF, 4'h5, 32'h0,          N, N, 32'h0);
        vt[4]  = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h5, 32'h0,          Y, N, 32'hDEADBEEF);
        vt[5]  = mk(Y, 4'hF, 4'h3, 32'h11223344,   N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'h0, 4'h3, 32'h11223344,   N, N, 32'h0);
        vt[6]  = mk(N, 4'h0, 4'h0, 32'h0,          Y, 4'h5, 4'h3, 32'hAABBCCDD,   N, Y, N, 4'hA, 4'h3, 32'hAABBCCDD,   N, N, 32'h0);
        vt[7]  = mk(N, 4'h0, 4'h0, 32'h0,          Y, 4'h0, 4'h3, 32'h0,          N, Y, N, 4'hF, 4'h3, 32'h0,          N, N, 32'h0);
        vt[8]  = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h3, 32'h0,          N, Y, 32'h11BB33DD);
        // contention, last winner R1 -> R0,R1,R0,R1
        vt[9]  = mk(Y, 4'h0, 4'h5, 32'h0,          Y, 4'h0, 4'h3, 32'h0,          Y, N, N, 4'hF, 4'h5, 32'h0,          N, N, 32'h0);
        vt[10] = mk(Y, 4'h0, 4'h5, 32'h0,          Y, 4'h0, 4'h3, 32'h0,          N, Y, N, 4'hF, 4'h3, 32'h0,          Y, N, 32'hDEADBEEF);
        vt[11] = mk(Y, 4'h0, 4'h5, 32'h0,          Y, 4'h0, 4'h3, 32'h0,          Y, N, N, 4'hF, 4'h5, 32'h0,          N, Y, 32'h11BB33DD);
        vt[12] = mk(Y, 4'h0, 4'h5, 32'h0,          Y, 4'h0, 4'h3, 32'h0,          N, Y, N, 4'hF, 4'h3, 32'h0,          Y, N, 32'hDEADBEEF);
        vt[13] = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h3, 32'h0,          N, Y, 32'h11BB33DD);
        // R1 loses to R0 then withdraws: no R1 access, no R1 rvalid
        vt[14] = mk(Y, 4'hF, 4'h7, 32'h00000055,   Y, 4'h0, 4'h3, 32'h0,          Y, N, N, 4'h0, 4'h7, 32'h00000055,   N, N, 32'h0);
        vt[15] = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h7, 32'h00000055,   N, N, 32'h0);
        vt[16] = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h7, 32'h00000055,   N, N, 32'h0);
        // write then read of the same address in the next cycle
        vt[17] = mk(N, 4'h0, 4'h0, 32'h0,          Y, 4'hF, 4'h6, 32'h0BADF00D,   N, Y, N, 4'h0, 4'h6, 32'h0BADF00D,   N, N, 32'h0);
        vt[18] = mk(Y, 4'h0, 4'h6, 32'h0,          N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'hF, 4'h6, 32'h0,          N, N, 32'h0);
        vt[19] = mk(Y, 4'h0, 4'h7, 32'h0,          N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'hF, 4'h7, 32'h0,          Y, N, 32'h0BADF00D);
        vt[20] = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h7, 32'h0,          Y, N, 32'h00000055);
        // second RUN segment, straight after a reset and refill
        vt[21] = mk(Y, 4'h0, 4'h2, 32'h0,          Y, 4'h0, 4'h4, 32'h0,          Y, N, N, 4'hF, 4'h2, 32'h0,          N, N, 32'h0);
        vt[22] = mk(Y, 4'hF, 4'h2, 32'h0000A002,   Y, 4'h0, 4'h4, 32'h0,          N, Y, N, 4'hF, 4'h4, 32'h0,          Y, N, 32'h0);
        vt[23] = mk(Y, 4'hF, 4'h2, 32'h0000A002,   N, 4'h0, 4'h0, 32'h0,          Y, N, N, 4'h0, 4'h2, 32'h0000A002,   N, Y, 32'h0);
        vt[24] = mk(N, 4'h0, 4'h0, 32'h0,          Y, 4'hF, 4'h4, 32'h0000B004,   N, Y, N, 4'h0, 4'h4, 32'h0000B004,   N, N, 32'h0);
        vt[25] = mk(Y, 4'h0, 4'h2, 32'h0,          Y, 4'h0, 4'h4, 32'h0,          Y, N, N, 4'hF, 4'h2, 32'h0,          N, N, 32'h0);
        vt[26] = mk(Y, 4'h0, 4'h2, 32'h0,          Y, 4'h0, 4'h4, 32'h0,          N, Y, N, 4'hF, 4'h4, 32'h0,          Y, N, 32'h0000A002);
        vt[27] = mk(Y, 4'h0, 4'h2, 32'h0,          Y, 4'h0, 4'h4, 32'h0,          Y, N, N, 4'hF, 4'h2, 32'h0,          N, Y, 32'h0000B004);
        vt[28] = mk(Y, 4'h0, 4'h2, 32'h0,          Y, 4'h0, 4'h4, 32'h0,          N, Y, N, 4'hF, 4'h4, 32'h0,          Y, N, 32'h0000A002);
        vt[29] = mk(N, 4'h0, 4'h0, 32'h0,          N, 4'h0, 4'h0, 32'h0,          N, N, Y, 4'hF, 4'h4, 32'h0,          N, Y, 32'h0000B004);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        n_vec = 0;
        n_bad = 0;
        fill_table();
        // Non-zero contents so a zero read proves the fill happened.
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA500_0000 | 32'($urandom_range(1, 16'hFFFF));

        // Requests held high through reset and INIT: none may be granted.
        idle_all();
        r0_if.req = 1'b1; r0_if.addr = 4'h1;
        r1_if.req = 1'b1; r1_if.addr = 4'h2;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset("rst");

        // Partial fill, then reset while init_ctr = 7.
        @(posedge clk); #1; rst = 1'b0;
        ramp(7, "fill");
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid");

        // Full fill restarting at address 0.
        @(posedge clk); #1; rst = 1'b0;
        ramp(16, "refill");

        for (int i = 0; i <= 20; i++) apply(i);

        // Read granted, then reset lands in the cycle its data would return.
        @(posedge clk); #1;
        idle_all();
        r0_if.req = 1'b1; r0_if.addr = 4'h5;
        @(negedge clk);
        chk("pend.gnt", r0_if.gnt, 1);
        @(posedge clk); #1;
        r0_if.req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("pend.rv0", r0_if.rvalid, 0);
        chk("pend.rv1", r1_if.rvalid, 0);
        @(posedge clk); #1; rst = 1'b0;
        ramp(16, "fill3");

        for (int i = 21; i < NVEC; i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
